clk_gen_downsampler: RTL and testbench

- Programmable clock divider clocked directly by the raw ring-oscillator output of the clk_gen inverter chain. It is the consumer end of the oscillator loop.
- Produces a 50%-duty divided clock, plus a one-cycle toggle strobe for downstream logic.
- The divide ratio is loaded through a valid/ready handshake. A new ratio is applied only at a full-period boundary, so the output never glitches or emits a runt pulse.

---
 rtl/clk_gen_downsampler.sv | 112 +++++++++++
 tb/tb_clk_gen_downsampler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_downsampler.sv
// clk_gen_downsampler
//   Programmable divider running directly off the raw ring-oscillator clock.
//   Produces a 50%-duty divided clock (clk_r_o) and a one-cycle strobe
//   (toggle_o) marking every edge of that clock. A new half-period ratio is
//   taken over a valid/ready handshake and only becomes active at the end of
//   a full output period (falling edge of clk_r_o), or immediately while the
//   divider is disabled and parked low, so the output never carries a runt.
//
// Ports
//   clk_i          raw oscillator clock
//   async_reset_i  asynchronous reset, active high
//   en_i           run enable; low freezes counter and output
//   val_i          data_i carries a ratio offer
//   data_i         half-period ratio N; output period = 2*(N+1) clk_i cycles
//   ready_o        a ratio can be accepted (no ratio pending)
//   clk_r_o        divided clock, registered
//   toggle_o       registered strobe, high in cycles where clk_r_o just changed

module clk_gen_downsampler #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               async_reset_i,
    input  logic               en_i,
    input  logic               val_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               clk_r_o,
    output logic               toggle_o
);

    localparam logic [width_p-1:0] ctr_one = {{(width_p-1){1'b0}}, 1'b1};

    logic [width_p-1:0] ctr_r;
    logic [width_p-1:0] ctr_n;
    logic [width_p-1:0] ratio_r;
    logic [width_p-1:0] ratio_n;
    logic [width_p-1:0] pend_r;
    logic [width_p-1:0] pend_n;
    logic               pend_v_r;
    logic               pend_v_n;
    logic               clk_n;
    logic               toggle_n;

    logic               terminal;
    logic               accept;
    logic               apply_run;
    logic               apply_idle;

    assign ready_o  = ~pend_v_r;
    assign accept   = val_i & ~pend_v_r;
    assign terminal = (ctr_r == ratio_r);

    // Running: swap ratio only where a high phase ends, so every full output
    // period is built from one ratio.
    assign apply_run  = en_i & terminal & clk_r_o & pend_v_r;
    // Disabled and parked low: no period is in flight, safe to swap now.
    assign apply_idle = ~en_i & ~clk_r_o & pend_v_r;

    // accept needs pend_v_r=0 while either apply needs pend_v_r=1, so the
    // two updates to the pending slot below never collide.
    always_comb begin
        ctr_n    = ctr_r;
        ratio_n  = ratio_r;
        pend_n   = pend_r;
        pend_v_n = pend_v_r;
        clk_n    = clk_r_o;
        toggle_n = 1'b0;

        if (accept) begin
            pend_n   = data_i;
            pend_v_n = 1'b1;
        end

        if (en_i) begin
            if (terminal) begin
                clk_n    = ~clk_r_o;
                ctr_n    = '0;
                toggle_n = 1'b1;
            end else begin
                ctr_n = ctr_r + ctr_one;
            end
        end

        // Counter restarts at zero with the new ratio, so a lower ratio can
        // never leave ctr_r stranded above the terminal value.
        if (apply_run || apply_idle) begin
            ratio_n  = pend_r;
            ctr_n    = '0;
            pend_v_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            ctr_r    <= '0;
            ratio_r  <= '0;
            pend_r   <= '0;
            pend_v_r <= 1'b0;
            clk_r_o  <= 1'b0;
            toggle_o <= 1'b0;
        end else begin
            ctr_r    <= ctr_n;
            ratio_r  <= ratio_n;
            pend_r   <= pend_n;
            pend_v_r <= pend_v_n;
            clk_r_o  <= clk_n;
            toggle_o <= toggle_n;
        end
    end

endmodule

// File: tb/tb_clk_gen_downsampler.sv
module tb_clk_gen_downsampler;

    logic       clk;
    logic       rst;
    logic       en;
    logic       val;
    logic [7:0] data;
    logic       ready;
    logic       clk_r;
    logic       toggle;

    clk_gen_downsampler #(.width_p(8)) dut (
        .clk_i        (clk),
        .async_reset_i(rst),
        .en_i         (en),
        .val_i        (val),
        .data_i       (data),
        .ready_o      (ready),
        .clk_r_o      (clk_r),
        .toggle_o     (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int tog_q[$];

    // Reference model: tracks cycles remaining in the current half period.
    bit m_clk;
    bit m_tog;
    int m_ratio;
    int m_pend;
    bit m_pend_v;
    int m_left;

    function automatic void model_reset();
        m_clk    = 0;
        m_tog    = 0;
        m_ratio  = 0;
        m_pend   = 0;
        m_pend_v = 0;
        m_left   = 1;
    endfunction

    function automatic void model_edge(bit e, bit v, int d);
        bit acc;
        bit fall;
        acc = v && !m_pend_v;
        if (e) begin
            if (m_left == 1) begin
                fall  = m_clk;
                m_clk = !m_clk;
                m_tog = 1;
                if (fall && m_pend_v) begin
                    m_ratio  = m_pend;
                    m_pend_v = 0;
                end
                m_left = m_ratio + 1;
            end else begin
                m_left = m_left - 1;
                m_tog  = 0;
            end
        end else begin
            m_tog = 0;
            if (!m_clk && m_pend_v) begin
                m_ratio  = m_pend;
                m_pend_v = 0;
                m_left   = m_ratio + 1;
            end
        end
        if (acc) begin
            m_pend   = d;
            m_pend_v = 1;
        end
    endfunction

    function automatic void check3(string name, logic [2:0] act, logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: clk/tog/rdy got %b expected %b", name, cyc, act, exp);
        end
    endfunction

    function automatic void check_int(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Inputs are driven just after an active edge; outputs sampled 1 time unit after.
    task automatic step(bit e, bit v, int d);
        en   = e;
        val  = v;
        data = d[7:0];
        @(posedge clk);
        model_edge(e, v, d);
        #1;
        cyc++;
        check3("model", {clk_r, toggle, ready}, {m_clk, m_tog, !m_pend_v});
        if (toggle) tog_q.push_back(cyc);
    endtask

    // Asynchronous reset applied between clock edges (called at posedge+1).
    task automatic do_reset();
        en  = 0;
        val = 0;
        #2;
        rst = 1;
        #1;
        check3("reset_immediate", {clk_r, toggle, ready}, 3'b001);
        model_reset();
        #3;
        rst = 0;
        tog_q.delete();
    endtask

    typedef struct {
        bit       en;
        bit       val;
        int       data;
        bit       e_clk;
        bit       e_tog;
        bit       e_rdy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int k;
        int cnt;

        // Reset then divide-by-2, then load 3 and watch the first 4/4 period.
        tbl[0]  = '{1, 0, 0, 1, 1, 1};
        tbl[1]  = '{1, 0, 0, 0, 1, 1};
        tbl[2]  = '{1, 0, 0, 1, 1, 1};
        tbl[3]  = '{1, 0, 0, 0, 1, 1};
        tbl[4]  = '{1, 1, 3, 1, 1, 0};
        tbl[5]  = '{1, 0, 0, 0, 1, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 0, 1, 1, 1};
        tbl[10] = '{1, 0, 0, 1, 0, 1};
        tbl[11] = '{1, 0, 0, 1, 0, 1};
        tbl[12] = '{1, 0, 0, 1, 0, 1};
        tbl[13] = '{1, 0, 0, 0, 1, 1};

        rst  = 1;
        en   = 0;
        val  = 0;
        data = 0;
        model_reset();
        #12;
        check3("reset_state", {clk_r, toggle, ready}, 3'b001);
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, tbl[i].val, tbl[i].data);
            check3($sformatf("tbl[%0d]", i), {clk_r, toggle, ready},
                   {tbl[i].e_clk, tbl[i].e_tog, tbl[i].e_rdy});
        end

        // Ratio 5 running, load 1 mid high phase: halves must be 6 then 2s.
        do_reset();
        step(0, 1, 5);
        step(0, 0, 0);
        tog_q.delete();
        k = 0;
        while (tog_q.size() < 1 && k < 50) begin step(1, 0, 0); k++; end
        check_int("r5_first_toggle", tog_q.size(), 1);
        step(1, 0, 0);
        step(1, 0, 0);
        check_int("r5_ready_before_load", int'(ready), 1);
        step(1, 1, 1);
        for (int i = 0; i < 30; i++) step(1, 0, 0);
        check_int("r5_high_len", tog_q[1] - tog_q[0], 6);
        for (int i = 2; i < tog_q.size(); i++)
            check_int("r1_half_len", tog_q[i] - tog_q[i-1], 2);

        // Back-to-back offers 7 then 9 with val held.
        do_reset();
        step(1, 1, 7);
        check_int("b2b_7_taken", int'(ready), 0);
        k = 0;
        step(1, 1, 9);
        while (!ready && k < 100) begin step(1, 1, 9); k++; end
        check_int("b2b_wait_bound", int'(k < 100), 1);
        step(1, 1, 9);
        check_int("b2b_9_taken", int'(ready), 0);
        tog_q.delete();
        for (int i = 0; i < 80; i++) step(1, 0, 0);
        check_int("b2b_ratio9_half_a", tog_q[tog_q.size()-1] - tog_q[tog_q.size()-2], 10);
        check_int("b2b_ratio9_half_b", tog_q[tog_q.size()-2] - tog_q[tog_q.size()-3], 10);

        // Disable while high at ctr=2 (ratio 4), offer ratio 0.
        do_reset();
        step(0, 1, 4);
        step(0, 0, 0);
        k = 0;
        tog_q.delete();
        while (tog_q.size() < 1 && k < 20) begin step(1, 0, 0); k++; end
        check_int("dis_low_phase", k, 5);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            check3("dis_hold_high", {clk_r, toggle, ready}, 3'b100);
        end
        cnt = 0;
        tog_q.delete();
        while (tog_q.size() < 1 && cnt < 20) begin step(1, 0, 0); cnt++; end
        check_int("dis_resume_edges", cnt, 3);
        check_int("dis_fell", int'(clk_r), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            check_int("dis_div2_toggle", int'(toggle), 1);
        end

        // Max ratio: half period of 256 cycles.
        do_reset();
        step(0, 1, 255);
        step(0, 0, 0);
        tog_q.delete();
        for (int i = 0; i < 600; i++) step(1, 0, 0);
        check_int("max_toggles", tog_q.size(), 2);
        check_int("max_half_len", tog_q[1] - tog_q[0], 256);

        // Async reset mid high phase with a ratio pending.
        do_reset();
        step(0, 1, 5);
        step(0, 0, 0);
        k = 0;
        while (tog_q.size() < 1 && k < 20) begin step(1, 0, 0); k++; end
        step(1, 0, 0);
        step(1, 1, 2);
        check3("pre_reset_high", {clk_r, toggle, ready}, 3'b100);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            check3("post_reset_div2", {clk_r, toggle, ready}, {(i % 2 == 0), 1'b1, 1'b1});
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit e;
            bit v;
            int d;
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
            step(e, v, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
